gray_step_tracker: RTL and testbench

Consumer of the 2-bit Gray-code phase stream produced by the gray counter FSM. It resynchronises the stream and decodes each legal one-bit transition into a forward or backward step. It keeps a wrapping position count and a revolution count, and flags illegal two-bit jumps. Sits directly downstream of the gray counter, feeding status and position logic.

---
 rtl/gray_step_tracker.sv | 176 +++++++++++++++++
 tb/tb_gray_step_tracker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_tracker.sv
// gray_step_tracker: resynchronises a 2-bit Gray phase stream and decodes each
// legal one-bit transition into a forward or backward step. It also keeps a
// wrapping position count and a wrapping revolution count. It flags illegal
// two-bit jumps and then parks in FAULT until clr or rst.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous reset, active-low
//   gray_in  - Gray phase from the upstream counter (may be asynchronous)
//   clr      - synchronous clear of counters, error count and FSM
//   position - step count modulo 2^POS_W
//   revs     - revolution count modulo 2^REV_W
//   step     - one-cycle pulse per legal transition
//   dir      - direction of the last legal step (1 forward, 0 backward)
//   err      - one-cycle pulse on an illegal jump
//   err_cnt  - saturating count of illegal jumps
//   fault    - high while parked in FAULT
module gray_step_tracker #(
   parameter int unsigned POS_W = 8,
   parameter int unsigned REV_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       gray_in,
   input  logic             clr,
   output logic [POS_W-1:0] position,
   output logic [REV_W-1:0] revs,
   output logic             step,
   output logic             dir,
   output logic             err,
   output logic [3:0]       err_cnt,
   output logic             fault
);

   localparam int unsigned ERR_W = 4;
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_TRACK = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   logic [1:0]       s1_q, s2_q;
   logic [1:0]       prev_q, prev_d;
   logic [1:0]       state_q, state_d;
   logic             init_cnt_q, init_cnt_d;
   logic [POS_W-1:0] position_q, position_d;
   logic [REV_W-1:0] revs_q, revs_d;
   logic             step_q, step_d;
   logic             dir_q, dir_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic             fault_q, fault_d;
   logic [1:0]       delta;

   // Gray to binary phase: 00->0, 01->1, 11->2, 10->3
   function automatic logic [1:0] phase_of(input logic [1:0] g);
      return {g[1], g[1] ^ g[0]};
   endfunction

   // Two-flop synchroniser for the asynchronous phase input
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= 2'b00;
         s2_q <= 2'b00;
      end else begin
         s1_q <= gray_in;
         s2_q <= s1_q;
      end
   end

   // Next-state and counter update
   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      init_cnt_d = init_cnt_q;
      position_d = position_q;
      revs_d     = revs_q;
      dir_d      = dir_q;
      err_cnt_d  = err_cnt_q;
      step_d     = 1'b0;
      err_d      = 1'b0;
      delta      = phase_of(s2_q) - phase_of(prev_q);

      if (clr) begin
         state_d    = ST_INIT;
         init_cnt_d = 1'b0;
         position_d = '0;
         revs_d     = '0;
         dir_d      = 1'b1;
         err_cnt_d  = '0;
      end else begin
         case (state_q)
            // Two flush clocks; whatever phase is settled becomes the start phase
            ST_INIT: begin
               if (init_cnt_q) begin
                  prev_d     = s2_q;
                  state_d    = ST_TRACK;
                  init_cnt_d = 1'b0;
               end else begin
                  init_cnt_d = 1'b1;
               end
            end
            ST_TRACK: begin
               prev_d = s2_q;
               case (delta)
                  2'd1: begin
                     step_d     = 1'b1;
                     dir_d      = 1'b1;
                     position_d = position_q + POS_W'(1);
                     // Crossing phase 3 -> 0 completes a forward revolution
                     if (prev_q == 2'b10 && s2_q == 2'b00) begin
                        revs_d = revs_q + REV_W'(1);
                     end
                  end
                  2'd3: begin
                     step_d     = 1'b1;
                     dir_d      = 1'b0;
                     position_d = position_q - POS_W'(1);
                     if (prev_q == 2'b00 && s2_q == 2'b10) begin
                        revs_d = revs_q - REV_W'(1);
                     end
                  end
                  2'd2: begin
                     err_d   = 1'b1;
                     state_d = ST_FAULT;
                     if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                     end
                  end
                  default: ;
               endcase
            end
            ST_FAULT: ;
            default: state_d = ST_INIT;
         endcase
      end

      // Registered fault flag tracks the state being entered
      fault_d = (state_d == ST_FAULT);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_INIT;
         prev_q     <= 2'b00;
         init_cnt_q <= 1'b0;
         position_q <= '0;
         revs_q     <= '0;
         step_q     <= 1'b0;
         dir_q      <= 1'b1;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         init_cnt_q <= init_cnt_d;
         position_q <= position_d;
         revs_q     <= revs_d;
         step_q     <= step_d;
         dir_q      <= dir_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
         fault_q    <= fault_d;
      end
   end

   assign position = position_q;
   assign revs     = revs_q;
   assign step     = step_q;
   assign dir      = dir_q;
   assign err      = err_q;
   assign err_cnt  = err_cnt_q;
   assign fault    = fault_q;

endmodule

// File: tb/tb_gray_step_tracker.sv
// Testbench for gray_step_tracker: directed scenarios plus random phase walks,
// checked by a scoreboard fed from a phase-index reference model.
module tb_gray_step_tracker;

   localparam int unsigned POS_W = 8;
   localparam int unsigned REV_W = 4;
   localparam int POS_MOD = 256;
   localparam int REV_MOD = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             clr = 1'b0;
   logic [1:0]       gray_in = 2'b00;
   logic [POS_W-1:0] position;
   logic [REV_W-1:0] revs;
   logic             step, dir, err, fault;
   logic [3:0]       err_cnt;

   gray_step_tracker #(.POS_W(POS_W), .REV_W(REV_W)) dut (
      .clk(clk), .rst(rst), .gray_in(gray_in), .clr(clr),
      .position(position), .revs(revs), .step(step), .dir(dir),
      .err(err), .err_cnt(err_cnt), .fault(fault)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      bit step;
      bit err;
      bit dir;
      int pos;
      int revs;
      int ecnt;
      bit fault;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int steps_seen = 0;
   int errs_seen = 0;

   // Reference model: phase as an index in the forward cycle
   logic [1:0] order [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   int         m_pos, m_revs, m_ecnt;
   bit         m_dir, m_fault;
   logic [1:0] m_prev;

   function automatic int idx_of(input logic [1:0] g);
      for (int i = 0; i < 4; i++) if (order[i] == g) return i;
      return 0;
   endfunction

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic model_sync();
      m_pos = 0; m_revs = 0; m_ecnt = 0; m_dir = 1'b1; m_fault = 1'b0;
      m_prev = gray_in;
   endtask

   // Drive a phase one clock; predict the response two edges after sampling
   task automatic drive(input logic [1:0] g);
      exp_t e;
      int d;
      @(negedge clk);
      gray_in = g;
      if (!m_fault && g != m_prev) begin
         d = (idx_of(g) - idx_of(m_prev) + 4) % 4;
         e.step = 1'b0;
         e.err  = 1'b0;
         if (d == 2) begin
            m_fault = 1'b1;
            if (m_ecnt < 15) m_ecnt++;
            e.err = 1'b1;
         end else if (d == 1) begin
            m_pos = (m_pos + 1) % POS_MOD;
            if (idx_of(g) == 0) m_revs = (m_revs + 1) % REV_MOD;
            m_dir = 1'b1;
            e.step = 1'b1;
         end else begin
            m_pos = (m_pos + POS_MOD - 1) % POS_MOD;
            if (idx_of(m_prev) == 0) m_revs = (m_revs + REV_MOD - 1) % REV_MOD;
            m_dir = 1'b0;
            e.step = 1'b1;
         end
         e.cyc = cyc + 3;
         e.dir = m_dir; e.pos = m_pos; e.revs = m_revs;
         e.ecnt = m_ecnt; e.fault = m_fault;
         exp_q.push_back(e);
         m_prev = g;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_position", int'(position), 0);
      check("rst_dir", int'(dir), 1);
      check("rst_fault", int'(fault), 0);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      model_sync();
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (3) @(negedge clk);
      model_sync();
   endtask

   // Monitor: every step/err pulse must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (rst && (step || err)) begin
         if (step) steps_seen++;
         if (err) errs_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got step=%0b err=%0b pos=%0d at cyc %0d, required no pulse",
                     step, err, position, cyc);
         end else begin
            e = exp_q.pop_front();
            if (cyc != e.cyc || step !== e.step || err !== e.err || dir !== e.dir ||
                int'(position) != e.pos || int'(revs) != e.revs ||
                int'(err_cnt) != e.ecnt || fault !== e.fault) begin
               errors++;
               $display("FAIL pulse: got cyc=%0d step=%0b err=%0b dir=%0b pos=%0d revs=%0d ecnt=%0d fault=%0b expected cyc=%0d step=%0b err=%0b dir=%0b pos=%0d revs=%0d ecnt=%0d fault=%0b",
                        cyc, step, err, dir, position, revs, err_cnt, fault,
                        e.cyc, e.step, e.err, e.dir, e.pos, e.revs, e.ecnt, e.fault);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base;
      int r;
      int i;

      // Reset values while held, then after release and flush
      repeat (3) @(negedge clk);
      check("reset_position", int'(position), 0);
      check("reset_revs", int'(revs), 0);
      check("reset_err_cnt", int'(err_cnt), 0);
      check("reset_step", int'(step), 0);
      check("reset_err", int'(err), 0);
      check("reset_fault", int'(fault), 0);
      check("reset_dir", int'(dir), 1);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("flush_position", int'(position), 0);
      check("flush_fault", int'(fault), 0);
      model_sync();

      // Forward run: 12 changes, three revolutions
      base = steps_seen;
      for (int k = 1; k <= 12; k++) drive(order[k % 4]);
      repeat (5) @(negedge clk);
      check("fwd_steps", steps_seen - base, 12);
      check("fwd_position", int'(position), 12);
      check("fwd_revs", int'(revs), 3);
      check("fwd_dir", int'(dir), 1);

      // Backward wrap from reset
      do_reset();
      base = steps_seen;
      drive(2'b10); drive(2'b11); drive(2'b01); drive(2'b00);
      repeat (5) @(negedge clk);
      check("bwd_steps", steps_seen - base, 4);
      check("bwd_position", int'(position), 252);
      check("bwd_revs", int'(revs), 15);
      check("bwd_dir", int'(dir), 0);

      // Illegal jump 01 -> 10, then input ignored in FAULT
      do_reset();
      base = errs_seen;
      drive(2'b01);
      drive(2'b10);
      repeat (5) @(negedge clk);
      check("ill_errs", errs_seen - base, 1);
      check("ill_err_cnt", int'(err_cnt), 1);
      check("ill_fault", int'(fault), 1);
      check("ill_position", int'(position), 1);
      drive(2'b11); drive(2'b01); drive(2'b00);
      repeat (5) @(negedge clk);
      check("fault_hold_position", int'(position), 1);
      check("fault_hold_fault", int'(fault), 1);

      // clr in FAULT in the cycle a legal change reaches s2
      @(negedge clk); gray_in = 2'b01;
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      check("clr_position", int'(position), 0);
      check("clr_err_cnt", int'(err_cnt), 0);
      check("clr_fault", int'(fault), 0);
      check("clr_dir", int'(dir), 1);
      repeat (3) @(negedge clk);
      model_sync();
      drive(2'b11);
      repeat (5) @(negedge clk);
      check("clr_recover_position", int'(position), 1);

      // clr coincides with the edge that would issue a step
      @(negedge clk); gray_in = 2'b10;
      @(negedge clk);
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      check("clr_prio_step", int'(step), 0);
      check("clr_prio_position", int'(position), 0);
      repeat (3) @(negedge clk);
      model_sync();

      // Random walk with occasional illegal jumps and clr recovery
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 19);
         i = idx_of(gray_in);
         if (r < 8) drive(gray_in);
         else if (r < 13) drive(order[(i + 1) % 4]);
         else if (r < 18) drive(order[(i + 3) % 4]);
         else begin
            drive(order[(i + 2) % 4]);
            repeat (5) @(negedge clk);
            check("rand_err_cnt", int'(err_cnt), 1);
            check("rand_fault", int'(fault), 1);
            do_clr();
         end
      end
      repeat (5) @(negedge clk);
      check("rand_position", int'(position), m_pos);
      check("rand_revs", int'(revs), m_revs);

      // Every predicted pulse must have been observed
      for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
